stage_sequencer: RTL and testbench

- Multi-cycle control FSM that sequences the non-pipelined core one stage at a time: fetch, decode/register-read, execute, memory, writeback.
- Drives the per-stage enables, including id_en and wb_en into the decode stage.
- Stalls on the instruction-memory and data-memory ready handshakes.
- Skips stages the current instruction does not need, counts retired instructions, and flags memory timeouts.

---
 rtl/stage_sequencer.sv | 218 +++++++++++++++++++++
 tb/tb_stage_sequencer.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stage_sequencer.sv
// ---------------------------------------------------------------------------
// stage_sequencer
//
// Multi-cycle control FSM for the non-pipelined core. Walks one instruction
// at a time through FETCH -> ID -> EX -> MEM -> WB, skipping the stages the
// current opcode class does not need, stalling on the instruction/data
// memory ready handshakes, and trapping into a sticky error state when a
// memory wait lasts too long.
//
// Parameters
//   TIMEOUT     max consecutive wait cycles in FETCH or MEM before error (>=1)
//   CNT_W       width of the retired-instruction counter
//
// Ports
//   clk         core clock, rising edge
//   reset       asynchronous, active-low reset
//   start       level; leaves IDLE (and chains instructions) when high
//   halt        level; only looked at on the retire cycle
//   imem_ready  fetch data valid this cycle (only meaningful in FETCH)
//   dmem_ready  load/store completes this cycle (only meaningful in MEM)
//   opcode      decoded opcode, stable from EX to the end of the instruction
//   if_en       fetch stage enable
//   id_en       decode/register-read enable
//   ex_en       ALU stage enable
//   mem_en      data memory request
//   wb_en       register-file writeback enable
//   pc_en       PC update strobe, high on the retire cycle of each instruction
//   busy        high in every state except IDLE and ERR
//   err         sticky memory-timeout flag
//   instr_count retired-instruction count, wraps modulo 2^CNT_W
// ---------------------------------------------------------------------------
module stage_sequencer #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             halt,
    input  logic             imem_ready,
    input  logic             dmem_ready,
    input  logic [6:0]       opcode,
    output logic             if_en,
    output logic             id_en,
    output logic             ex_en,
    output logic             mem_en,
    output logic             wb_en,
    output logic             pc_en,
    output logic             busy,
    output logic             err,
    output logic [CNT_W-1:0] instr_count
);

    // The wait counter only has to reach TIMEOUT-1.
    localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_ID,
        S_EX,
        S_MEM,
        S_WB,
        S_ERR
    } state_t;

    state_t            state;
    state_t            state_next;
    state_t            after_retire;
    logic [WAIT_W-1:0] wait_cnt;
    logic              is_load;
    logic              is_store;
    logic              is_branch;
    logic              retire;
    logic              wait_expired;
    logic              stalled;
    logic              entering_wait;

    // Opcode class decode. Only used from EX onwards, where the opcode is
    // guaranteed stable, so no local copy is kept.
    always_comb begin
        is_load   = (opcode == OP_LOAD);
        is_store  = (opcode == OP_STORE);
        is_branch = (opcode == OP_BRANCH);
    end

    // Retire is the last cycle of an instruction: EX for branches, the
    // completing MEM cycle for stores, and WB for everything else. The
    // PC strobe has to land in that same cycle, so it depends on the
    // opcode class and on dmem_ready rather than on the state alone.
    always_comb begin
        retire = 1'b0;
        case (state)
            S_EX:    retire = is_branch;
            S_MEM:   retire = dmem_ready && !is_load;
            S_WB:    retire = 1'b1;
            default: retire = 1'b0;
        endcase
    end

    assign pc_en = retire;

    // Stall bookkeeping for the two memory wait states. A ready seen in
    // the very cycle the budget runs out still wins over the timeout.
    always_comb begin
        stalled      = ((state == S_FETCH) && !imem_ready) ||
                       ((state == S_MEM)   && !dmem_ready);
        wait_expired = stalled && (wait_cnt == WAIT_LAST);
    end

    // Where to go once an instruction retires: halt beats start.
    always_comb begin
        if (halt) begin
            after_retire = S_IDLE;
        end else if (start) begin
            after_retire = S_FETCH;
        end else begin
            after_retire = S_IDLE;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_next = S_FETCH;
                end
            end
            S_FETCH: begin
                if (imem_ready) begin
                    state_next = S_ID;
                end else if (wait_expired) begin
                    state_next = S_ERR;
                end
            end
            S_ID: begin
                state_next = S_EX;
            end
            S_EX: begin
                if (is_load || is_store) begin
                    state_next = S_MEM;
                end else if (is_branch) begin
                    state_next = after_retire;
                end else begin
                    state_next = S_WB;
                end
            end
            S_MEM: begin
                if (dmem_ready) begin
                    state_next = is_load ? S_WB : after_retire;
                end else if (wait_expired) begin
                    state_next = S_ERR;
                end
            end
            S_WB: begin
                state_next = after_retire;
            end
            S_ERR: begin
                state_next = S_ERR;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // The wait counter restarts whenever a wait state is freshly entered.
    always_comb begin
        entering_wait = ((state_next == S_FETCH) && (state != S_FETCH)) ||
                        ((state_next == S_MEM)   && (state != S_MEM));
    end

    // State register, wait counter, retire counter and registered outputs.
    // The stage enables are decoded from the next state so that they are
    // flops that line up exactly with the registered state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= S_IDLE;
            wait_cnt    <= '0;
            instr_count <= '0;
            if_en       <= 1'b0;
            id_en       <= 1'b0;
            ex_en       <= 1'b0;
            mem_en      <= 1'b0;
            wb_en       <= 1'b0;
            busy        <= 1'b0;
            err         <= 1'b0;
        end else begin
            state <= state_next;

            if (entering_wait) begin
                wait_cnt <= '0;
            end else if (stalled && !wait_expired) begin
                wait_cnt <= wait_cnt + WAIT_W'(1);
            end

            if (retire) begin
                instr_count <= instr_count + CNT_W'(1);
            end

            if_en  <= (state_next == S_FETCH);
            id_en  <= (state_next == S_ID);
            ex_en  <= (state_next == S_EX);
            mem_en <= (state_next == S_MEM);
            wb_en  <= (state_next == S_WB);
            busy   <= (state_next != S_IDLE) && (state_next != S_ERR);
            err    <= (state_next == S_ERR);
        end
    end

endmodule

// File: tb/tb_stage_sequencer.sv
// ---------------------------------------------------------------------------
// tb_stage_sequencer
//
// Self-checking bench for stage_sequencer. A behavioural model describes the
// running instruction as a string of stage letters (F, D, E, M, W) built
// from its opcode class, plus a position and a stall counter; outputs are
// checked against it every cycle. Directed scenarios pin the model with
// literal stage traces and counts, then a randomized phase runs.
// ---------------------------------------------------------------------------
module tb_stage_sequencer;

    localparam int TIMEOUT = 16;
    localparam int CNT_W   = 32;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_ALU    = 7'b0110011;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic             halt;
    logic             imem_ready;
    logic             dmem_ready;
    logic [6:0]       opcode;
    logic             if_en;
    logic             id_en;
    logic             ex_en;
    logic             mem_en;
    logic             wb_en;
    logic             pc_en;
    logic             busy;
    logic             err;
    logic [CNT_W-1:0] instr_count;

    int compared   = 0;
    int mismatched = 0;

    // Model state: 0 = idle, 1 = running an instruction, 2 = error.
    int               m_mode;
    string            m_stages;
    int               m_pos;
    int               m_wait;
    logic [CNT_W-1:0] m_count;
    logic [6:0]       cur_op;
    logic [6:0]       next_op;

    string trace;
    string pc_trace;

    stage_sequencer #(
        .TIMEOUT(TIMEOUT),
        .CNT_W  (CNT_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .halt       (halt),
        .imem_ready (imem_ready),
        .dmem_ready (dmem_ready),
        .opcode     (opcode),
        .if_en      (if_en),
        .id_en      (id_en),
        .ex_en      (ex_en),
        .mem_en     (mem_en),
        .wb_en      (wb_en),
        .pc_en      (pc_en),
        .busy       (busy),
        .err        (err),
        .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [63:0] actual,
                                input logic [63:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic string stages_for(input logic [6:0] op);
        string s;
        s = "FDE";
        if (op == OP_LOAD) begin
            s = {s, "MW"};
        end else if (op == OP_STORE) begin
            s = {s, "M"};
        end else if (op != OP_BRANCH) begin
            s = {s, "W"};
        end
        return s;
    endfunction

    function automatic byte model_stage();
        byte c;
        c = "-";
        if (m_mode == 1) begin
            c = m_stages[m_pos];
        end
        return c;
    endfunction

    function automatic bit stage_done(input byte c, input bit ir, input bit dr);
        if (c == "F") return ir;
        if (c == "M") return dr;
        return 1'b1;
    endfunction

    function automatic byte dut_stage();
        if (if_en)  return "F";
        if (id_en)  return "D";
        if (ex_en)  return "E";
        if (mem_en) return "M";
        if (wb_en)  return "W";
        return "-";
    endfunction

    task automatic model_reset();
        m_mode  = 0;
        m_pos   = 0;
        m_wait  = 0;
        m_count = '0;
    endtask

    task automatic model_begin();
        cur_op   = next_op;
        m_stages = stages_for(cur_op);
        m_pos    = 0;
        m_wait   = 0;
        m_mode   = 1;
    endtask

    // Advance the model by one clock edge using the inputs sampled there.
    task automatic model_step(input bit s, input bit h, input bit ir, input bit dr);
        byte c;
        if (m_mode == 0) begin
            if (s) model_begin();
        end else if (m_mode == 1) begin
            c = m_stages[m_pos];
            if (stage_done(c, ir, dr)) begin
                if (m_pos == m_stages.len() - 1) begin
                    m_count = m_count + 1'b1;
                    if (h)      m_mode = 0;
                    else if (s) model_begin();
                    else        m_mode = 0;
                end else begin
                    m_pos  = m_pos + 1;
                    m_wait = 0;
                end
            end else if (m_wait == TIMEOUT - 1) begin
                m_mode = 2;
            end else begin
                m_wait = m_wait + 1;
            end
        end
    endtask

    // One clock cycle: drive at posedge+1, compare at negedge, step model
    // on the posedge, return at posedge+1.
    task automatic apply_stimulus(input bit s, input bit h, input bit ir, input bit dr);
        byte        c;
        bit         last;
        logic [7:0] exp_vec;
        start      = s;
        halt       = h;
        imem_ready = ir;
        dmem_ready = dr;
        opcode     = cur_op;
        @(negedge clk);
        c    = model_stage();
        last = (m_mode == 1) && (m_pos == m_stages.len() - 1);
        exp_vec = {c == "F", c == "D", c == "E", c == "M", c == "W",
                   last && stage_done(c, ir, dr), m_mode == 1, m_mode == 2};
        check_output("outputs", {56'd0, if_en, id_en, ex_en, mem_en, wb_en, pc_en, busy, err},
                     {56'd0, exp_vec});
        check_output("instr_count", {32'd0, instr_count}, {32'd0, m_count});
        trace    = $sformatf("%s%c", trace, dut_stage());
        pc_trace = $sformatf("%s%0d", pc_trace, pc_en);
        @(posedge clk);
        model_step(s, h, ir, dr);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        #1;
        check_output("reset_outputs", {56'd0, if_en, id_en, ex_en, mem_en, wb_en, pc_en, busy, err}, 64'd0);
        check_output("reset_count", {32'd0, instr_count}, 64'd0);
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    task automatic clear_trace();
        trace    = "";
        pc_trace = "";
    endtask

    task automatic check_trace(input string name, input string exp_t, input string exp_pc);
        compared++;
        if (trace != exp_t || pc_trace != exp_pc) begin
            mismatched++;
            $display("[TB] FAIL %s: got %s/%s, expected %s/%s", name, trace, pc_trace, exp_t, exp_pc);
        end
    endtask

    initial begin
        string exp_t;
        string exp_pc;
        int    r;

        reset      = 1'b0;
        start      = 1'b0;
        halt       = 1'b0;
        imem_ready = 1'b0;
        dmem_ready = 1'b0;
        cur_op     = OP_ALU;
        next_op    = OP_ALU;
        opcode     = OP_ALU;
        m_stages   = "";
        model_reset();
        clear_trace();
        @(posedge clk);
        #1;
        do_reset();

        // ALU instruction, start pulsed once.
        next_op = OP_ALU;
        apply_stimulus(1, 0, 1, 1);
        clear_trace();
        repeat (5) apply_stimulus(0, 0, 1, 1);
        check_trace("alu_seq", "FDEW-", "00010");
        check_output("alu_count", {32'd0, instr_count}, 64'd1);

        // LOAD with three data-memory stall cycles.
        next_op = OP_LOAD;
        apply_stimulus(1, 0, 1, 1);
        clear_trace();
        repeat (3) apply_stimulus(0, 0, 1, 1);
        repeat (3) apply_stimulus(0, 0, 1, 0);
        repeat (3) apply_stimulus(0, 0, 1, 1);
        check_trace("load_stall", "FDEMMMMW-", "000000010");
        check_output("load_count", {32'd0, instr_count}, 64'd2);

        // STORE then BRANCH back to back with start held.
        next_op = OP_STORE;
        apply_stimulus(1, 0, 1, 1);
        next_op = OP_BRANCH;
        clear_trace();
        repeat (6) apply_stimulus(1, 0, 1, 1);
        apply_stimulus(0, 0, 1, 1);
        apply_stimulus(0, 0, 1, 1);
        check_trace("store_branch", "FDEMFDE-", "00010010");
        check_output("sb_count", {32'd0, instr_count}, 64'd4);

        // Halt raised in EX with start held: instruction completes, then idle.
        next_op = OP_ALU;
        apply_stimulus(1, 0, 1, 1);
        clear_trace();
        apply_stimulus(1, 0, 1, 1);
        apply_stimulus(1, 0, 1, 1);
        apply_stimulus(1, 1, 1, 1);
        apply_stimulus(1, 1, 1, 1);
        apply_stimulus(0, 0, 1, 1);
        apply_stimulus(0, 0, 1, 1);
        check_trace("halt_in_ex", "FDEW--", "000100");
        check_output("halt_count", {32'd0, instr_count}, 64'd5);

        // Reset in the middle of a LOAD's MEM stall.
        next_op = OP_LOAD;
        apply_stimulus(1, 0, 1, 1);
        repeat (3) apply_stimulus(0, 0, 1, 1);
        apply_stimulus(0, 0, 1, 0);
        check_output("mem_before_reset", {63'd0, mem_en}, 64'd1);
        do_reset();
        next_op = OP_ALU;
        apply_stimulus(1, 0, 1, 1);
        clear_trace();
        repeat (5) apply_stimulus(0, 0, 1, 1);
        check_trace("after_reset", "FDEW-", "00010");
        check_output("after_reset_count", {32'd0, instr_count}, 64'd1);

        // Fetch timeout: 16 stalled fetch cycles then sticky error.
        apply_stimulus(1, 0, 0, 0);
        clear_trace();
        repeat (TIMEOUT) apply_stimulus(1, 0, 0, 0);
        repeat (3) apply_stimulus(1, 1, 1, 1);
        exp_t  = "";
        exp_pc = "";
        for (int i = 0; i < TIMEOUT; i++) begin
            exp_t  = {exp_t, "F"};
            exp_pc = {exp_pc, "0"};
        end
        check_trace("timeout", {exp_t, "---"}, {exp_pc, "000"});
        check_output("timeout_err", {62'd0, err, busy}, 64'd2);
        do_reset();

        // Ready on the last allowed fetch cycle wins over the timeout.
        apply_stimulus(1, 0, 0, 0);
        clear_trace();
        repeat (TIMEOUT - 1) apply_stimulus(0, 0, 0, 1);
        repeat (4) apply_stimulus(0, 0, 1, 1);
        exp_t  = "";
        exp_pc = "";
        for (int i = 0; i < TIMEOUT; i++) begin
            exp_t  = {exp_t, "F"};
            exp_pc = {exp_pc, "0"};
        end
        check_trace("late_ready", {exp_t, "DEW"}, {exp_pc, "001"});
        check_output("late_ready_err", {63'd0, err}, 64'd0);

        // Randomized phase against the model.
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            r = $urandom_range(0, 3);
            case (r)
                0:       next_op = OP_LOAD;
                1:       next_op = OP_STORE;
                2:       next_op = OP_BRANCH;
                default: next_op = 7'($urandom);
            endcase
            if ($urandom_range(0, 400) == 0) begin
                do_reset();
            end else if ((n % 1000) > 900) begin
                // Long stall window so timeouts are actually reached.
                apply_stimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                               1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 19) == 0));
            end else begin
                apply_stimulus($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 2,
                               $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
            end
            if (m_mode == 2 && $urandom_range(0, 7) == 0) do_reset();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
